// File: rtl/memaccess.sv
// DLX memory-access stage: latches execute results, runs the data-memory req/ack
// transaction, aligns/extends load data and formats store data/byte enables.
module memaccess #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clock5,
  input  logic        reset5,
  input  logic [31:0] inst_in4,
  input  logic [31:0] alu_in4,
  input  logic [31:0] store_data_in4,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic [31:0] inst_out5,
  output logic [31:0] alu_out5,
  output logic [31:0] loadmemdata_out,
  output logic        stall_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [TO_W-1:0] CNT_MAX = TO_W'(ACK_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [31:0]     ir4_q, alu4_q, sd4_q;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic [5:0]  opcode;
  logic [1:0]  off;
  logic        is_load, is_store, sext;
  size_t       size;
  logic        misaligned, mem_op, timeout;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign opcode = ir4_q[31:26];
  assign off    = alu4_q[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_WORD;
    case (opcode)
      6'b000001: begin is_load  = 1'b1; size = SZ_BYTE; sext = 1'b1; end
      6'b000010: begin is_load  = 1'b1; size = SZ_BYTE; end
      6'b000011: begin is_load  = 1'b1; size = SZ_HALF; sext = 1'b1; end
      6'b000100: begin is_load  = 1'b1; size = SZ_HALF; end
      6'b000101: begin is_load  = 1'b1; size = SZ_WORD; end
      6'b001001: begin is_store = 1'b1; size = SZ_BYTE; end
      6'b001011: begin is_store = 1'b1; size = SZ_HALF; end
      6'b001101: begin is_store = 1'b1; size = SZ_WORD; end
      default:   ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (is_load || is_store) begin
      if (size == SZ_HALF)      misaligned = off[0];
      else if (size == SZ_WORD) misaligned = (off != 2'b00);
    end
  end

  assign mem_op = (is_load || is_store) && !misaligned;

  // Stage registers hold while a memory access is outstanding.
  always_ff @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      ir4_q  <= '0;
      alu4_q <= '0;
      sd4_q  <= '0;
    end else if (!stall_out) begin
      ir4_q  <= inst_in4;
      alu4_q <= alu_in4;
      sd4_q  <= store_data_in4;
    end
  end

  always_ff @(posedge clock5 or negedge reset5) begin
    if (!reset5) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // The counter already advances in the IDLE request cycle, so req stays up
  // for exactly ACK_TIMEOUT cycles before being abandoned.
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    timeout    = 1'b0;
    stall_out  = 1'b0;
    cnt_d      = '0;
    misalign_d = misalign_q | misaligned;
    bus_err_d  = bus_err_q;

    case (state_q)
      S_IDLE: dmem_req = mem_op;
      S_WAIT: dmem_req = 1'b1;
      default: dmem_req = 1'b0;
    endcase

    timeout   = dmem_req && !dmem_ack && (cnt_q == CNT_MAX);
    stall_out = mem_op && !dmem_ack && !timeout;

    if (dmem_req && !dmem_ack && !timeout) cnt_d = cnt_q + 1'b1;
    if (timeout) bus_err_d = 1'b1;

    case (state_q)
      S_IDLE: if (stall_out) state_d = S_WAIT;
      S_WAIT: if (dmem_ack || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (mem_op) begin
      if (is_load) begin
        dmem_be = 4'b1111;
      end else begin
        dmem_we = 1'b1;
        case (size)
          SZ_BYTE: begin
            dmem_be    = 4'b1000 >> off;
            dmem_wdata = {4{sd4_q[7:0]}};
          end
          SZ_HALF: begin
            dmem_be    = off[1] ? 4'b0011 : 4'b1100;
            dmem_wdata = {2{sd4_q[15:0]}};
          end
          default: begin
            dmem_be    = 4'b1111;
            dmem_wdata = sd4_q;
          end
        endcase
      end
    end
  end

  assign dmem_addr = {alu4_q[31:2], 2'b00};

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    case (off)
      2'd0:    byte_sel = dmem_rdata[31:24];
      2'd1:    byte_sel = dmem_rdata[23:16];
      2'd2:    byte_sel = dmem_rdata[15:8];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
  end

  always_comb begin
    loadmemdata_out = '0;
    if (mem_op && is_load && dmem_ack) begin
      case (size)
        SZ_BYTE: loadmemdata_out = {{24{sext & byte_sel[7]}}, byte_sel};
        SZ_HALF: loadmemdata_out = {{16{sext & half_sel[15]}}, half_sel};
        default: loadmemdata_out = dmem_rdata;
      endcase
    end
  end

  assign inst_out5    = (!stall_out && !misaligned && !timeout) ? ir4_q : 32'h0;
  assign alu_out5     = alu4_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/memaccess.md
Name: memaccess

Overview:
- DLX memory-access stage, between execute and writeback.
- Latches IR4, ALU result and store data from execute, and runs the data-memory transaction with a req/ack handshake.
- Aligns and extends load data; formats store data and byte enables.
- Presents inst_out5/alu_out5/loadmemdata_out, which writeback registers on the next posedge clock5. Stalls upstream while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 16: maximum number of cycles dmem_req stays high without dmem_ack before the access is abandoned.
- TO_W, 5: width of the wait counter; must hold ACK_TIMEOUT-1.

Ports:
- clock5  in  1  stage clock
- reset5  in  1  asynchronous, active-low reset
- inst_in4  in  32  instruction from execute
- alu_in4  in  32  ALU result / effective address from execute
- store_data_in4  in  32  rt value for stores
- dmem_ack  in  1  memory completes access this cycle
- dmem_rdata  in  32  read data, valid only when dmem_ack=1
- dmem_req  out  1  access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word address, alu4 with bits[1:0]=00
- dmem_be  out  4  byte enables; be[3]=bits 31:24 (big-endian)
- dmem_wdata  out  32  replicated store data
- inst_out5  out  32  instruction to writeback (0 = bubble)
- alu_out5  out  32  ALU result to writeback
- loadmemdata_out  out  32  aligned, extended load data
- stall_out  out  1  execute must hold its outputs
- misalign_err  out  1  sticky: a misaligned access occurred
- bus_err  out  1  sticky: an access timed out

Behaviour:
- Reset is asynchronous and active-low on reset5; clock is clock5.
- Reset values:
  - ir4, alu4, sd4, wait counter and both sticky flags reset to 0; FSM resets to IDLE.
  - All outputs are therefore 0: req, we, be, addr, wdata, inst_out5, stall_out.
- Opcodes are ir4[31:26]:
  - Loads: LB=000001, LBU=000010, LH=000011, LHU=000100, LW=000101.
  - Stores: SB=001001, SH=001011, SW=001101.
  - All other opcodes are non-memory.
- Stage registers ir4/alu4/sd4 load from the inputs on posedge clock5 when stall_out=0; they hold when stall_out=1.
- Let off = alu4[1:0]. Misaligned means: half access with off[0]=1, or word access with off!=00.
- mem_op = aligned load or store in ir4.
- FSM:
  - IDLE: dmem_req=mem_op. If mem_op & ~dmem_ack, go to WAIT. Zero-wait (ack in the same cycle) stays in IDLE.
  - WAIT: dmem_req=1; addr/we/be/wdata held stable. On dmem_ack, go to IDLE. On timeout, go to IDLE.
- Wait counter:
  - Cleared in IDLE.
  - Increments each cycle with req & ~ack.
  - Timeout is the cycle in which counter==ACK_TIMEOUT-1 and ~dmem_ack. On the following edge bus_err is set, the counter is cleared and the state returns to IDLE.
- stall_out = mem_op & ~dmem_ack & ~timeout. This is combinational from dmem_ack.
- The completion cycle is the cycle in which stall_out=0:
  - inst_out5 = ir4 for a non-memory op or an acked access.
  - inst_out5 = 0 when stalled, misaligned or timed out.
  - alu_out5 = alu4 always.
- Load data:
  - loadmemdata_out = extended dmem_rdata in the acked cycle of a load, else 0.
  - Byte select: off=0 takes bits 31:24, off=3 takes bits 7:0.
  - Half select: off=0 takes bits 31:16, off=2 takes bits 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store data:
  - SB: be=one-hot at bit (3-off), wdata={4{sd[7:0]}}.
  - SH: be=1100 for off=0 or 0011 for off=2, wdata={2{sd[15:0]}}.
  - SW: be=1111, wdata=sd.
  - Loads: be=1111, we=0.
  - No access: be=0, wdata=0, we=0.
- Misaligned access:
  - No dmem_req; the instruction completes in one cycle as a bubble.
  - misalign_err is set at that edge.
  - Sticky flags are cleared only by reset5.
- Reset mid-WAIT:
  - dmem_req drops asynchronously and the transaction is abandoned.
  - Memory must ignore a late ack.
  - A late dmem_ack while in IDLE with no mem_op is ignored.

Test Plan:
- Reset then ADDI (opcode 010000), alu_in4=0x0000002A → next cycle inst_out5=inst, alu_out5=0x2A, dmem_req=0, stall_out=0.
- LB, alu=0x103, ack same cycle, rdata=0x123456F0 → loadmemdata_out=0xFFFFFFF0, no stall, dmem_addr=0x100.
- LHU, alu=0x202, ack after 2 wait cycles, rdata=0xAAAA8001 → stall_out=1 for 2 cycles, inst_out5=0 during stall, then loadmemdata_out=0x00008001.
- SB, alu=0x301, sd=0x000000C3 → dmem_we=1, be=0100, wdata=0xC3C3C3C3; SW to 0x300 → be=1111.
- LW, alu=0x102 → no dmem_req, inst_out5=0, misalign_err=1 and it stays 1 until reset5.
- LW with ack never asserted → req high for exactly 16 cycles, then stall_out=0, inst_out5=0, bus_err=1; assert reset5 mid-WAIT → req=0 immediately.
